pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central hazard, flush and trap sequencer for the five-stage pipeline. It replaces the scattered bubble/flush/IRQ glue between the IF, ID, EX and MEM stages. It watches ID/EX/MEM status and produces every stall, flush and trap-entry control signal from one state machine. It also keeps a saturating stall counter for performance measurement.

## Interface
- `TRAP_IRQ`, default 2'd1: cause code reported for an interrupt.
- `TRAP_EXC`, default 2'd2: cause code reported for an undefined-instruction exception.
- `CNT_W`, default 16: width of the stall counter.

- `clk` in 1: CPU clock, which is the divided clock, not clk_50m.
- `reset` in 1: synchronous, active-high.
- `id_rs` in 5: Rs field of the instruction in ID.
- `id_rt` in 5: Rt field of the instruction in ID.
- `id_uses_rt` in 1: ID instruction reads Rt as a source.
- `id_valid` in 1: ID holds a real instruction, not a bubble or a flushed slot.
- `id_kernel` in 1: PC[31] of the ID instruction (supervisor mode).
- `id_jump` in 1: ID decodes a J, JAL, JR or JALR.
- `id_undef` in 1: ID decodes an undefined opcode.
- `ex_memread` in 1: ID_EX MemRead.
- `ex_rt` in 5: ID_EX Rt.
- `ex_is_branch` in 1: EX holds a conditional branch.
- `ex_branch_taken` in 1: EX branch resolved taken (PCSrcB).
- `irq_req` in 1: level interrupt from the peripheral block.
- `ext_wait` in 1: UART/bus wait (uart_wait).
- `pc_hold` out 1: PC does not update.
- `ifid_hold` out 1: IF_ID register holds.
- `if_flush` out 1: IF_ID loads a bubble.
- `id_flush` out 1: ID_EX loads a bubble.
- `pipe_hold` out 1: ID_EX, EX_MEM and MEM_WB hold.
- `trap_take` out 1: PC loads the trap vector; EPC is written with the PC of the ID instruction.
- `trap_cause` out 2: cause code, valid while trap_take is high.
- `stall_cnt` out CNT_W: saturating count of cycles in which pc_hold was high.

## Operation
- States:
  - RUN: normal flow.
  - WAIT: an external wait is in progress.
  - DRAIN: a trap is pending and the pipeline is not yet ready to take it.
  - TRAP: a one-cycle trap entry.
- irq_pend register:
  - Set on any cycle with irq_req=1 and id_kernel=0, in any state.
  - Cleared only on the cycle trap_take=1 with cause TRAP_IRQ.
- RUN outputs are combinational. Priority, highest first:
  1. ext_wait: pc_hold, ifid_hold and pipe_hold all 1. No flush. Next state is WAIT.
  2. ex_branch_taken: if_flush=1 and id_flush=1. The load-use, jump and trap checks of this cycle are discarded.
  3. id_undef & id_valid: next state is TRAP with cause EXC. id_flush=1 this cycle.
  4. irq_pend & ~id_kernel: next state is DRAIN.
  5. Load-use (ex_memread and ex_rt≠0 and (ex_rt==id_rs or (id_uses_rt and ex_rt==id_rt))): pc_hold=1, ifid_hold=1, id_flush=1.
  6. id_jump: if_flush=1.
- WAIT:
  - All three holds are 1 while ext_wait=1.
  - When ext_wait=0 the state returns to RUN in the same cycle, and RUN rules apply combinationally that cycle.
  - Events arriving during WAIT are not lost: irq_pend latches, and branch, load-use and jump inputs are held by the frozen stages.
- DRAIN:
  - Priority rules 1, 2, 5 and 6 still apply.
  - Moves to TRAP when id_valid=1, ex_is_branch=0, ext_wait=0 and there is no load-use hazard.
  - If id_undef becomes valid during DRAIN, the trap cause becomes EXC. irq_pend remains set.
- TRAP (exactly 1 cycle):
  - Outputs: trap_take=1, trap_cause set, if_flush=1, id_flush=1, pc_hold=0.
  - Next state is RUN.
  - If ext_wait rises during TRAP, the trap still completes. WAIT is entered on the next cycle.
- stall_cnt increments by 1 on each cycle with pc_hold=1 and saturates at all-ones.

## Timing
- Reset (synchronous, active-high):
  - State is RUN, irq_pend=0, stall_cnt=0, trap_cause=0.
  - While reset=1, every output is forced to 0.
  - Reset asserted in the middle of DRAIN, WAIT or TRAP aborts the sequence. No trap_take is produced afterwards.
- Hazard outputs (hold and flush) are combinational from the current state and inputs, with zero latency.
- trap_take and trap_cause are registered Moore outputs of TRAP.
- Interrupt latency:
  - irq_req sampled at edge N sets irq_pend at N.
  - DRAIN holds in cycle N+1.
  - trap_take is asserted at the earliest in cycle N+2.
- Undefined-instruction latency: trap_take is asserted in the cycle after the undefined instruction sits in ID.
- A taken branch in the same cycle as irq_pend keeps the state in DRAIN. The trap is retried on the branch target.
- stall_cnt updates at the edge following each counted cycle.

## Test plan
- Load-use: `lw $t0` in EX (ex_memread=1, ex_rt=8) with `add` in ID (id_rs=8). Required: one cycle of pc_hold=ifid_hold=id_flush=1, stall_cnt=1, then normal flow.
- Taken branch while a jump and a load-use hazard are also in ID. Required: if_flush=id_flush=1 only, pc_hold=0, stall_cnt unchanged.
- irq_req pulsed for 1 cycle with id_kernel=0 while a branch is in EX for 2 cycles. Required: DRAIN for 2 cycles, then one cycle of trap_take=1 with trap_cause=1, and irq_pend cleared. The same pulse with id_kernel=1 produces no trap.
- ext_wait high for 5 cycles, with irq_req pulsed during that time. Required: all holds high for 5 cycles, no flush, then DRAIN, then a trap with cause 1.
- id_undef=1 with id_valid=1 while irq_pend=1. Required: the next cycle has trap_take=1 with trap_cause=2, and irq_pend is still 1.
- Force stall_cnt to 16'hFFFE, then hold load-use for 3 cycles. Required: the counter reaches FFFF and stays there. Assert reset during DRAIN. Required: the next cycle is RUN with all outputs 0 and no trap_take.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Central stall / flush / trap-entry sequencer for the five-stage pipeline.
// Hold and flush outputs are combinational from state and stage status;
// trap_take / trap_cause are Moore outputs of the one-cycle TRAP state.
module pipeline_ctrl #(
  parameter logic [1:0]  TRAP_IRQ = 2'd1,
  parameter logic [1:0]  TRAP_EXC = 2'd2,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_valid,
  input  logic             id_kernel,
  input  logic             id_jump,
  input  logic             id_undef,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic             ex_is_branch,
  input  logic             ex_branch_taken,
  input  logic             irq_req,
  input  logic             ext_wait,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             if_flush,
  output logic             id_flush,
  output logic             pipe_hold,
  output logic             trap_take,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_TRAP  = 2'd3;

  logic [1:0]       state, state_nx;
  logic [1:0]       cause_q, cause_nx;
  logic             irq_pend, irq_pend_nx;
  logic [CNT_W-1:0] stall_q;

  logic pc_hold_c, ifid_hold_c, if_flush_c, id_flush_c, pipe_hold_c;
  logic trap_take_c;
  logic load_use_c;
  logic undef_c;

  // Load-use hazard: the load in EX writes a register the ID instruction reads.
  always_comb begin
    load_use_c = ex_memread && (ex_rt != 5'd0) &&
                 ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    undef_c    = id_undef && id_valid;
  end

  // Next state and combinational hazard outputs.
  always_comb begin
    state_nx    = state;
    cause_nx    = cause_q;
    pc_hold_c   = 1'b0;
    ifid_hold_c = 1'b0;
    if_flush_c  = 1'b0;
    id_flush_c  = 1'b0;
    pipe_hold_c = 1'b0;

    case (state)
      ST_TRAP: begin
        if_flush_c = 1'b1;
        id_flush_c = 1'b1;
        state_nx   = ST_RUN;
      end

      ST_DRAIN: begin
        if (ext_wait) begin
          pc_hold_c   = 1'b1;
          ifid_hold_c = 1'b1;
          pipe_hold_c = 1'b1;
          state_nx    = ST_WAIT;
        end else if (ex_branch_taken) begin
          // Stay in DRAIN; the trap is retried on the branch target.
          if_flush_c = 1'b1;
          id_flush_c = 1'b1;
        end else begin
          if (load_use_c) begin
            pc_hold_c   = 1'b1;
            ifid_hold_c = 1'b1;
            id_flush_c  = 1'b1;
          end else if (id_jump) begin
            if_flush_c = 1'b1;
          end
          if (id_valid && !ex_is_branch && !load_use_c) begin
            state_nx = ST_TRAP;
            cause_nx = undef_c ? TRAP_EXC : TRAP_IRQ;
          end
        end
      end

      // WAIT with ext_wait low behaves as RUN in the same cycle; with ext_wait
      // high the RUN rules already produce the full hold.
      default: begin
        if (ext_wait) begin
          pc_hold_c   = 1'b1;
          ifid_hold_c = 1'b1;
          pipe_hold_c = 1'b1;
          state_nx    = ST_WAIT;
        end else if (ex_branch_taken) begin
          if_flush_c = 1'b1;
          id_flush_c = 1'b1;
          state_nx   = ST_RUN;
        end else if (undef_c) begin
          id_flush_c = 1'b1;
          state_nx   = ST_TRAP;
          cause_nx   = TRAP_EXC;
        end else begin
          // A pending interrupt only schedules DRAIN; ID hazards still apply
          // so the pipeline stays correct while the trap is waited on.
          state_nx = (irq_pend && !id_kernel) ? ST_DRAIN : ST_RUN;
          if (load_use_c) begin
            pc_hold_c   = 1'b1;
            ifid_hold_c = 1'b1;
            id_flush_c  = 1'b1;
          end else if (id_jump) begin
            if_flush_c = 1'b1;
          end
        end
      end
    endcase
  end

  // Pending-interrupt latch: set wins over the clear of an IRQ trap entry.
  always_comb begin
    trap_take_c = (state == ST_TRAP);
    irq_pend_nx = (irq_req && !id_kernel) ||
                  (irq_pend && !(trap_take_c && (cause_q == TRAP_IRQ)));
  end

  // State, cause, pending-interrupt and saturating stall counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_RUN;
      cause_q  <= 2'd0;
      irq_pend <= 1'b0;
      stall_q  <= '0;
    end else begin
      state    <= state_nx;
      cause_q  <= cause_nx;
      irq_pend <= irq_pend_nx;
      if (pc_hold_c && (stall_q != {CNT_W{1'b1}})) begin
        stall_q <= stall_q + CNT_W'(1);
      end
    end
  end

  // Every output is forced low while reset is asserted.
  always_comb begin
    pc_hold    = pc_hold_c   && !reset;
    ifid_hold  = ifid_hold_c && !reset;
    if_flush   = if_flush_c  && !reset;
    id_flush   = id_flush_c  && !reset;
    pipe_hold  = pipe_hold_c && !reset;
    trap_take  = trap_take_c && !reset;
    trap_cause = trap_take ? cause_q : 2'd0;
    stall_cnt  = reset ? '0 : stall_q;
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: hazards, flushes, trap sequencing, counter.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_uses_rt, id_valid, id_kernel, id_jump, id_undef;
  logic        ex_memread, ex_is_branch, ex_branch_taken, irq_req, ext_wait;
  logic        pc_hold, ifid_hold, if_flush, id_flush, pipe_hold, trap_take;
  logic [1:0]  trap_cause;
  logic [15:0] stall_cnt;

  int asserts = 0;
  int fails   = 0;

  // Flag order: pc_hold ifid_hold if_flush id_flush pipe_hold trap_take
  wire [5:0] o = {pc_hold, ifid_hold, if_flush, id_flush, pipe_hold, trap_take};

  pipeline_ctrl dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_valid(id_valid),
    .id_kernel(id_kernel), .id_jump(id_jump), .id_undef(id_undef),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .ex_is_branch(ex_is_branch),
    .ex_branch_taken(ex_branch_taken), .irq_req(irq_req), .ext_wait(ext_wait),
    .pc_hold(pc_hold), .ifid_hold(ifid_hold), .if_flush(if_flush),
    .id_flush(id_flush), .pipe_hold(pipe_hold), .trap_take(trap_take),
    .trap_cause(trap_cause), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Baseline inputs: a valid user-mode instruction with no hazards.
  task automatic idle();
    reset = 1'b0; id_rs = 5'd1; id_rt = 5'd2; id_uses_rt = 1'b0;
    id_valid = 1'b1; id_kernel = 1'b0; id_jump = 1'b0; id_undef = 1'b0;
    ex_memread = 1'b0; ex_rt = 5'd0; ex_is_branch = 1'b0;
    ex_branch_taken = 1'b0; irq_req = 1'b0; ext_wait = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
    idle();
  endtask

  task automatic test_reset();
    step(); reset = 1'b1; ext_wait = 1'b1; ex_memread = 1'b1; ex_rt = 5'd1; #1;
    asserts++; if (o !== 6'b000000) begin fails++; $display("FAIL rst_flags got %b want %b", o, 6'b000000); end
    asserts++; if (stall_cnt !== 16'd0) begin fails++; $display("FAIL rst_cnt got %h want 0", stall_cnt); end
    step(); #1;
    asserts++; if (o !== 6'b000000) begin fails++; $display("FAIL rst_run got %b want %b", o, 6'b000000); end
    asserts++; if (trap_cause !== 2'd0) begin fails++; $display("FAIL rst_cause got %0d want 0", trap_cause); end
  endtask

  task automatic test_load_use();
    step(); ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; #1;
    asserts++; if (o !== 6'b110100) begin fails++; $display("FAIL lu_rs got %b want %b", o, 6'b110100); end
    asserts++; if (stall_cnt !== 16'd0) begin fails++; $display("FAIL lu_cnt0 got %h want 0", stall_cnt); end
    step(); #1;
    asserts++; if (o !== 6'b000000) begin fails++; $display("FAIL lu_after got %b want %b", o, 6'b000000); end
    asserts++; if (stall_cnt !== 16'd1) begin fails++; $display("FAIL lu_cnt1 got %h want 1", stall_cnt); end
    step(); ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd3; id_rt = 5'd8; id_uses_rt = 1'b1; #1;
    asserts++; if (o !== 6'b110100) begin fails++; $display("FAIL lu_rt got %b want %b", o, 6'b110100); end
    step(); ex_memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; #1;
    asserts++; if (o !== 6'b000000) begin fails++; $display("FAIL lu_r0 got %b want %b", o, 6'b000000); end
    asserts++; if (stall_cnt !== 16'd2) begin fails++; $display("FAIL lu_cnt2 got %h want 2", stall_cnt); end
    step(); ex_memread = 1'b1; ex_rt = 5'd9; id_rt = 5'd9; id_uses_rt = 1'b0; #1;
    asserts++; if (o !== 6'b000000) begin fails++; $display("FAIL lu_nort got %b want %b", o, 6'b000000); end
    step(); id_jump = 1'b1; #1;
    asserts++; if (o !== 6'b001000) begin fails++; $display("FAIL jump got %b want %b", o, 6'b001000); end
  endtask

  task automatic test_branch();
    step(); ex_is_branch = 1'b1; ex_branch_taken = 1'b1; id_jump = 1'b1;
    ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_undef = 1'b1; #1;
    asserts++; if (o !== 6'b001100) begin fails++; $display("FAIL br_flags got %b want %b", o, 6'b001100); end
    step(); #1;
    asserts++; if (o !== 6'b000000) begin fails++; $display("FAIL br_notrap got %b want %b", o, 6'b000000); end
    asserts++; if (stall_cnt !== 16'd2) begin fails++; $display("FAIL br_cnt got %h want 2", stall_cnt); end
  endtask

  task automatic test_irq();
    logic [5:0] exp_o [8];
    exp_o = '{6'b000000, 6'b000000, 6'b000000, 6'b000000,
              6'b001101, 6'b000000, 6'b000000, 6'b000000};
    for (int i = 0; i < 8; i++) begin
      step();
      if (i == 0) irq_req = 1'b1;
      if (i == 1 || i == 2) ex_is_branch = 1'b1;
      #1;
      asserts++; if (o !== exp_o[i]) begin fails++; $display("FAIL irq_c%0d got %b want %b", i, o, exp_o[i]); end
      if (i == 4) begin
        asserts++; if (trap_cause !== 2'd1) begin fails++; $display("FAIL irq_cause got %0d want 1", trap_cause); end
      end
    end
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 0) begin irq_req = 1'b1; id_kernel = 1'b1; end
      #1;
      asserts++; if (o !== 6'b000000) begin fails++; $display("FAIL irq_kern_c%0d got %b want %b", i, o, 6'b000000); end
    end
  endtask

  task automatic test_wait();
    for (int i = 0; i < 5; i++) begin
      step(); ext_wait = 1'b1; id_jump = 1'b1;
      if (i == 1) irq_req = 1'b1;
      #1;
      asserts++; if (o !== 6'b110010) begin fails++; $display("FAIL wait_c%0d got %b want %b", i, o, 6'b110010); end
    end
    step(); #1;
    asserts++; if (o !== 6'b000000) begin fails++; $display("FAIL wait_end got %b want %b", o, 6'b000000); end
    asserts++; if (stall_cnt !== 16'd7) begin fails++; $display("FAIL wait_cnt got %h want 7", stall_cnt); end
    step(); #1;
    asserts++; if (o !== 6'b000000) begin fails++; $display("FAIL wait_drain got %b want %b", o, 6'b000000); end
    step(); #1;
    asserts++; if (o !== 6'b001101) begin fails++; $display("FAIL wait_trap got %b want %b", o, 6'b001101); end
    asserts++; if (trap_cause !== 2'd1) begin fails++; $display("FAIL wait_cause got %0d want 1", trap_cause); end
    step(); #1;
    asserts++; if (o !== 6'b000000) begin fails++; $display("FAIL wait_post got %b want %b", o, 6'b000000); end
  endtask

  task automatic test_undef_irq();
    logic [5:0] exp_o [7];
    logic [1:0] exp_c [7];
    exp_o = '{6'b000000, 6'b000100, 6'b001101, 6'b000000, 6'b000000, 6'b001101, 6'b000000};
    exp_c = '{2'd0, 2'd0, 2'd2, 2'd0, 2'd0, 2'd1, 2'd0};
    for (int i = 0; i < 7; i++) begin
      step();
      if (i == 0) irq_req = 1'b1;
      if (i == 1) id_undef = 1'b1;
      #1;
      asserts++; if (o !== exp_o[i]) begin fails++; $display("FAIL undef_c%0d got %b want %b", i, o, exp_o[i]); end
      if (exp_o[i][0]) begin
        asserts++; if (trap_cause !== exp_c[i]) begin fails++; $display("FAIL undef_cause_c%0d got %0d want %0d", i, trap_cause, exp_c[i]); end
      end
    end
  endtask

  task automatic test_drain_undef();
    logic [5:0] exp_o [9];
    logic [1:0] exp_c [9];
    exp_o = '{6'b000000, 6'b000000, 6'b001100, 6'b000000, 6'b001101,
              6'b000000, 6'b000000, 6'b001101, 6'b000000};
    exp_c = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0, 2'd1, 2'd0};
    for (int i = 0; i < 9; i++) begin
      step();
      if (i == 0) irq_req = 1'b1;
      if (i == 1) ex_is_branch = 1'b1;
      if (i == 2) begin ex_is_branch = 1'b1; ex_branch_taken = 1'b1; end
      if (i == 3) id_undef = 1'b1;
      #1;
      asserts++; if (o !== exp_o[i]) begin fails++; $display("FAIL drain_c%0d got %b want %b", i, o, exp_o[i]); end
      if (exp_o[i][0]) begin
        asserts++; if (trap_cause !== exp_c[i]) begin fails++; $display("FAIL drain_cause_c%0d got %0d want %0d", i, trap_cause, exp_c[i]); end
      end
    end
  endtask

  task automatic test_saturate();
    step();
    force dut.stall_q = 16'hFFFE;
    @(posedge clk); #1;
    release dut.stall_q;
    for (int i = 0; i < 4; i++) begin
      step();
      if (i < 3) begin ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; end
      #1;
      asserts++;
      if (stall_cnt !== ((i == 0) ? 16'hFFFE : 16'hFFFF)) begin
        fails++; $display("FAIL sat_c%0d got %h want %h", i, stall_cnt, (i == 0) ? 16'hFFFE : 16'hFFFF);
      end
    end
  endtask

  task automatic test_reset_drain();
    step(); irq_req = 1'b1; #1;
    step(); ex_is_branch = 1'b1; #1;
    step(); reset = 1'b1; #1;
    asserts++; if (o !== 6'b000000) begin fails++; $display("FAIL rstd_flags got %b want %b", o, 6'b000000); end
    asserts++; if (stall_cnt !== 16'd0) begin fails++; $display("FAIL rstd_cnt got %h want 0", stall_cnt); end
    for (int i = 0; i < 4; i++) begin
      step(); #1;
      asserts++; if (o !== 6'b000000) begin fails++; $display("FAIL rstd_c%0d got %b want %b", i, o, 6'b000000); end
    end
    asserts++; if (stall_cnt !== 16'd0) begin fails++; $display("FAIL rstd_cnt_after got %h want 0", stall_cnt); end
  endtask

  initial begin
    idle();
    reset = 1'b1;
    test_reset();
    test_load_use();
    test_branch();
    test_irq();
    test_wait();
    test_undef_irq();
    test_drain_undef();
    test_saturate();
    test_reset_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
